button_event_decoder: RTL and testbench

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/button_event_decoder_pkg.sv | 32 +++
 rtl/button_event_decoder_event_timer.sv | 37 +++
 rtl/button_event_decoder.sv | 125 ++++++++++++
 tb/tb_button_event_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/button_event_decoder_pkg.sv
// Shared types and defaults for the button gesture decoder.
package button_event_decoder_pkg;

    localparam int unsigned LONG_CYCLES_DEF   = 8;
    localparam int unsigned DCLICK_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_WAIT_SECOND,
        ST_SECOND_PRESSED,
        ST_LONG_HELD
    } state_e;

    // Registered event/status bundle driven to the outputs
    typedef struct packed {
        logic busy;
        logic long_press;
        logic double_click;
        logic short_click;
        logic release_pulse;
        logic press_pulse;
    } evt_t;

    function automatic int unsigned cnt_width(input int unsigned long_c,
                                              input int unsigned dclick_c);
        int unsigned m;
        m = (long_c > dclick_c) ? long_c : dclick_c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_event_decoder_event_timer.sv
// Clearable saturating cycle counter with a terminal-count compare.
module event_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] tc_val_i,
    output logic             tc_c_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/button_event_decoder.sv
// Decodes a clean button level into press/release, short, double and long gestures.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int unsigned DCLICK_CYCLES = DCLICK_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic db_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_click,
    output logic double_click,
    output logic long_press,
    output logic busy
);

    localparam int unsigned CNT_W = cnt_width(LONG_CYCLES, DCLICK_CYCLES);
    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CYCLES - 1);

    state_e           state_q;
    state_e           state_d;
    evt_t             evt_q;
    evt_t             evt_d;
    logic             tmr_clr;
    logic             tmr_inc;
    logic [CNT_W-1:0] tmr_tc_val;
    logic             tmr_tc;

    event_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (tmr_clr),
        .inc_i    (tmr_inc),
        .tc_val_i (tmr_tc_val),
        .tc_c_o   (tmr_tc)
    );

    // Next state, timer control and next-cycle pulses
    always_comb begin
        state_d    = state_q;
        evt_d      = '0;
        tmr_clr    = 1'b0;
        tmr_inc    = 1'b0;
        tmr_tc_val = LONG_TC;

        unique case (state_q)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (db_in) begin
                    state_d           = ST_PRESSED;
                    evt_d.press_pulse = 1'b1;
                end
            end
            ST_PRESSED, ST_SECOND_PRESSED: begin
                if (!db_in) begin
                    tmr_clr             = 1'b1;
                    evt_d.release_pulse = 1'b1;
                    if (state_q == ST_PRESSED) begin
                        state_d = ST_WAIT_SECOND;
                    end else begin
                        state_d            = ST_IDLE;
                        evt_d.double_click = 1'b1;
                    end
                end else if (tmr_tc) begin
                    tmr_clr          = 1'b1;
                    state_d          = ST_LONG_HELD;
                    evt_d.long_press = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_WAIT_SECOND: begin
                tmr_tc_val = DCLICK_TC;
                // A press on the timeout edge takes priority over the click
                if (db_in) begin
                    tmr_clr           = 1'b1;
                    state_d           = ST_SECOND_PRESSED;
                    evt_d.press_pulse = 1'b1;
                end else if (tmr_tc) begin
                    tmr_clr           = 1'b1;
                    state_d           = ST_IDLE;
                    evt_d.short_click = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                tmr_clr = 1'b1;
                if (!db_in) begin
                    state_d             = ST_IDLE;
                    evt_d.release_pulse = 1'b1;
                end
            end
            default: begin
                tmr_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        evt_d.busy = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            evt_q   <= evt_d;
        end
    end

    assign press_pulse   = evt_q.press_pulse;
    assign release_pulse = evt_q.release_pulse;
    assign short_click   = evt_q.short_click;
    assign double_click  = evt_q.double_click;
    assign long_press    = evt_q.long_press;
    assign busy          = evt_q.busy;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed and randomized checks of button_event_decoder with a per-edge scoreboard.
module tb_button_event_decoder;

    localparam int unsigned L = 8;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic reset;
    logic db_in;
    logic press_pulse, release_pulse, short_click, double_click, long_press, busy;

    int vectors = 0;
    int miscompares = 0;

    // {busy, long, double, short, release, press}
    logic [5:0] exp_q[$];
    logic [5:0] prev_obs = '0;
    logic       btn_down = 1'b0;

    // Reference model: run-length view of the gesture
    int m_ph  = 0;
    int m_run = 0;

    button_event_decoder #(
        .LONG_CYCLES   (L),
        .DCLICK_CYCLES (D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .db_in         (db_in),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_click   (short_click),
        .double_click  (double_click),
        .long_press    (long_press),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic db, input logic rst, input logic [5:0] exp, input string tag);
        logic [5:0] obs;
        logic [5:0] e;
        @(negedge clk);
        db_in = db;
        reset = rst;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        obs = {busy, long_press, double_click, short_click, release_pulse, press_pulse};
        e = exp_q.pop_front();
        check(tag, obs, e);
        // Invariants: one gesture pulse at a time, single-cycle pulses, press/release alternate
        check({tag, "_onehot"}, 1'(!$onehot0(obs[4:2])), 1'b0);
        check({tag, "_width"}, prev_obs[4:0] & obs[4:0], 5'b0);
        if (obs[0]) begin
            check({tag, "_alt_press"}, btn_down, 1'b0);
            btn_down = 1'b1;
        end
        if (obs[1]) begin
            check({tag, "_alt_release"}, btn_down, 1'b1);
            btn_down = 1'b0;
        end
        if (rst) btn_down = 1'b0;
        prev_obs = obs;
    endtask

    task automatic model_edge(input logic db, input logic rst, output logic [5:0] e);
        e = '0;
        if (rst) begin
            m_ph = 0;
        end else begin
            case (m_ph)
                0: if (db) begin e[0] = 1'b1; m_ph = 1; m_run = 1; end
                1, 3: begin
                    if (!db) begin
                        e[1] = 1'b1;
                        if (m_ph == 3) e[3] = 1'b1;
                        m_ph = (m_ph == 1) ? 2 : 0;
                        m_run = 0;
                    end else begin
                        m_run++;
                        if (m_run == int'(L) + 1) begin e[4] = 1'b1; m_ph = 4; end
                    end
                end
                2: begin
                    m_run++;
                    if (db) begin e[0] = 1'b1; m_ph = 3; m_run = 1; end
                    else if (m_run == int'(D)) begin e[2] = 1'b1; m_ph = 0; end
                end
                default: if (!db) begin e[1] = 1'b1; m_ph = 0; end
            endcase
        end
        e[5] = (m_ph != 0);
    endtask

    initial begin
        logic [5:0] e;
        logic       lvl;
        int         left;
        logic       r;

        db_in = 1'b0;
        reset = 1'b1;

        // Reset state
        step(1'b0, 1'b1, 6'b000000, "reset0");
        step(1'b0, 1'b1, 6'b000000, "reset1");
        step(1'b0, 1'b0, 6'b000000, "idle");

        // Short click: high 3, low 6
        step(1'b1, 1'b0, 6'b100001, "sc_press");
        step(1'b1, 1'b0, 6'b100000, "sc_hold");
        step(1'b1, 1'b0, 6'b100000, "sc_hold");
        step(1'b0, 1'b0, 6'b100010, "sc_release");
        step(1'b0, 1'b0, 6'b100000, "sc_win1");
        step(1'b0, 1'b0, 6'b100000, "sc_win2");
        step(1'b0, 1'b0, 6'b100000, "sc_win3");
        step(1'b0, 1'b0, 6'b000100, "sc_click");
        step(1'b0, 1'b0, 6'b000000, "sc_idle");

        // Double click: high 2, low 2, high 2, low
        step(1'b1, 1'b0, 6'b100001, "dc_press1");
        step(1'b1, 1'b0, 6'b100000, "dc_hold1");
        step(1'b0, 1'b0, 6'b100010, "dc_release1");
        step(1'b0, 1'b0, 6'b100000, "dc_gap");
        step(1'b1, 1'b0, 6'b100001, "dc_press2");
        step(1'b1, 1'b0, 6'b100000, "dc_hold2");
        step(1'b0, 1'b0, 6'b001010, "dc_double");
        step(1'b0, 1'b0, 6'b000000, "dc_idle");

        // Long press: high 12, long_press after 9th high edge
        step(1'b1, 1'b0, 6'b100001, "lp_press");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 6'b100000, "lp_hold");
        step(1'b1, 1'b0, 6'b110000, "lp_long");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'b100000, "lp_held");
        step(1'b0, 1'b0, 6'b000010, "lp_release");
        step(1'b0, 1'b0, 6'b000000, "lp_idle");

        // Second press on the last window edge wins over the timeout
        step(1'b1, 1'b0, 6'b100001, "edge_press1");
        step(1'b0, 1'b0, 6'b100010, "edge_release1");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'b100000, "edge_win");
        step(1'b1, 1'b0, 6'b100001, "edge_press2");
        step(1'b0, 1'b0, 6'b001010, "edge_double");
        step(1'b0, 1'b0, 6'b000000, "edge_idle");

        // Long hold on the second press: long_press, no double_click
        step(1'b1, 1'b0, 6'b100001, "sl_press1");
        step(1'b0, 1'b0, 6'b100010, "sl_release1");
        step(1'b1, 1'b0, 6'b100001, "sl_press2");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 6'b100000, "sl_hold");
        step(1'b1, 1'b0, 6'b110000, "sl_long");
        step(1'b0, 1'b0, 6'b000010, "sl_release2");

        // Reset in WAIT_SECOND, db_in held high through reset release
        step(1'b1, 1'b0, 6'b100001, "rw_press");
        step(1'b0, 1'b0, 6'b100010, "rw_release");
        step(1'b0, 1'b0, 6'b100000, "rw_wait");
        step(1'b0, 1'b1, 6'b000000, "rw_reset");
        step(1'b1, 1'b1, 6'b000000, "rw_reset_hi");
        step(1'b1, 1'b0, 6'b100001, "rw_first_press");
        step(1'b0, 1'b0, 6'b100010, "rw_release2");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'b100000, "rw_win");
        step(1'b0, 1'b0, 6'b000100, "rw_click");

        // Reset mid long-hold discards the gesture
        step(1'b1, 1'b0, 6'b100001, "rp_press");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'b100000, "rp_hold");
        step(1'b1, 1'b1, 6'b000000, "rp_reset");
        step(1'b0, 1'b0, 6'b000000, "rp_idle");
        step(1'b0, 1'b0, 6'b000000, "rp_idle2");

        // Randomized level runs against the reference model
        model_edge(1'b0, 1'b1, e);
        step(1'b0, 1'b1, e, "rand_reset");
        lvl  = 1'b0;
        left = 0;
        for (int i = 0; i < 10000; i++) begin
            if (left == 0) begin
                lvl  = ~lvl;
                left = int'($urandom_range(1, 11));
            end
            left--;
            r = ($urandom_range(0, 999) == 0);
            model_edge(lvl, r, e);
            step(lvl, r, e, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
